// File: rtl/pdm_decimator.sv
// PDM to PCM converter: 3rd-order CIC decimator, ratio 2^RATE_LOG2.
// Define PDM_DECIMATOR_SYNC_EN to add a 2-flop input synchronizer.
module pdm_decimator #(
    parameter int DATA_BITS = 12,
    parameter int RATE_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid
);

    localparam int GW = 3 * RATE_LOG2;
    localparam int W  = GW + 1;

    localparam logic [W-1:0] FULL = {1'b1, {GW{1'b0}}};
    localparam logic [RATE_LOG2-1:0] LAST = '1;
    localparam logic [RATE_LOG2-1:0] CNT_ONE = 1;

    logic din_s;
    logic en_s;

`ifdef PDM_DECIMATOR_SYNC_EN
    logic [1:0] din_sync_q;
    logic [1:0] din_sync_d;
    logic [1:0] en_sync_q;
    logic [1:0] en_sync_d;

    always_comb begin
        din_sync_d = {din_sync_q[0], din};
        en_sync_d  = {en_sync_q[0], din_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync_q <= '0;
            en_sync_q  <= '0;
        end else begin
            din_sync_q <= din_sync_d;
            en_sync_q  <= en_sync_d;
        end
    end

    assign din_s = din_sync_q[1];
    assign en_s  = en_sync_q[1];
`else
    assign din_s = din;
    assign en_s  = din_en;
`endif

    logic [W-1:0] i1_q, i1_d;
    logic [W-1:0] i2_q, i2_d;
    logic [W-1:0] i3_q, i3_d;
    logic [RATE_LOG2-1:0] cnt_q, cnt_d;
    logic dec_q, dec_d;

    // Integrators wrap freely; the comb differences cancel the wrap.
    always_comb begin
        i1_d  = i1_q;
        i2_d  = i2_q;
        i3_d  = i3_q;
        cnt_d = cnt_q;
        dec_d = 1'b0;
        if (en_s) begin
            i1_d  = i1_q + {{(W-1){1'b0}}, din_s};
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = cnt_q + CNT_ONE;
            dec_d = (cnt_q == LAST);
        end
    end

    logic [W-1:0] c1;
    logic [W-1:0] c2;
    logic [W-1:0] c3;
    logic [W-1:0] d1_q, d1_d;
    logic [W-1:0] d2_q, d2_d;
    logic [W-1:0] d3_q, d3_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic valid_q, valid_d;

    always_comb begin
        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;
    end

    always_comb begin
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (dec_q) begin
            d1_d    = i3_q;
            d2_d    = c1;
            d3_d    = c2;
            valid_d = 1'b1;
            // Full-scale result is one past the top code; clamp it.
            if (c3 == FULL) begin
                dout_d = '1;
            end else begin
                dout_d = c3[GW-1 -: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            i3_q    <= i3_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator using an exact-integer CIC model.
// Expected samples are queued per frame and matched on dout_valid.
module tb_pdm_decimator;

    localparam int DB = 12;
    localparam int RL = 6;
    localparam int R  = 1 << RL;
`ifdef PDM_DECIMATOR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic din_en;
    logic [DB-1:0] dout;
    logic dout_valid;

    pdm_decimator #(.DATA_BITS(DB), .RATE_LOG2(RL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_en     (din_en),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int val;
        int at_cyc;
    } exp_t;

    exp_t sb[$];
    int vals[$];
    int pcyc[$];

    // Model: exact running sums, comb as third difference of frame sums.
    longint s1, s2, s3, h1, h2, h3;
    int mcnt;
    bit alt;
    int dac_acc;

    task automatic model_reset();
        s1 = 0; s2 = 0; s3 = 0;
        h1 = 0; h2 = 0; h3 = 0;
        mcnt = 0;
        alt = 1'b1;
        dac_acc = 0;
        sb.delete();
    endtask

    task automatic model_accept(input bit b);
        longint c;
        exp_t e;
        s3 = s3 + s2;
        s2 = s2 + s1;
        s1 = s1 + longint'(b);
        mcnt++;
        if (mcnt == R) begin
            mcnt = 0;
            c = s3 - 3 * h1 + 3 * h2 - h3;
            h3 = h2;
            h2 = h1;
            h1 = s3;
            if (c == longint'(1) << (3 * RL)) c = c - 1;
            e.val = int'(c >> (3 * RL - DB));
            e.at_cyc = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dout_valid === 1'b1) begin
            vals.push_back(int'(dout));
            pcyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", dout, e.val);
                check("valid_cycle", cyc, e.at_cyc);
            end
        end
    end

    function automatic int vat(input int i);
        return (vals.size() > i) ? vals[i] : -1;
    endfunction

    function automatic int cat(input int i);
        return (pcyc.size() > i) ? pcyc[i] : -1;
    endfunction

    task automatic step(input bit d, input bit en);
        din = d;
        din_en = en;
        @(posedge clk);
        #1;
        if (en) model_accept(d);
    endtask

    task automatic run(input int kind, input int n);
        bit d;
        bit en;
        int sum;
        for (int i = 0; i < n; i++) begin
            d = 1'b1;
            en = 1'b1;
            case (kind)
                1: d = 1'b0;
                2: begin
                    d = alt;
                    alt = ~alt;
                end
                3: en = (i % 2 == 0);
                4: begin
                    sum = dac_acc + 1000;
                    d = sum[12];
                    dac_acc = sum & 4095;
                end
                default: ;
            endcase
            step(d, en);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        din = 1'b0;
        din_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vals.delete();
        pcyc.delete();
    endtask

    initial begin
        int facc;
        int d;
        rst_n = 1'b0;
        din = 1'b0;
        din_en = 1'b0;
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);

        // All ones: 651 first, saturates to 4095, 64-cycle spacing
        do_reset();
        check("rel_dout", dout, 0);
        run(0, 7 * R);
        drain();
        check("ones_first", vat(0), 651);
        for (int i = 3; i < 7; i++) check("ones_sat", vat(i), 4095);
        for (int i = 1; i < 7; i++)
            check("ones_space", cat(i) - cat(i - 1), R);

        // All zeros
        do_reset();
        run(1, 5 * R);
        drain();
        check("zeros_cnt", vals.size(), 5);
        check("zeros_last", vat(4), 0);

        // Alternating 1,0
        do_reset();
        run(2, 6 * R);
        drain();
        for (int i = 3; i < 6; i++) check("alt_mid", vat(i), 2048);

        // Ones with din_en toggling: same values, double spacing
        do_reset();
        run(3, 14 * R);
        drain();
        check("gap_first", vat(0), 651);
        check("gap_sat", vat(3), 4095);
        check("gap_space", cat(2) - cat(1), 2 * R);

        // First-order sigma-delta source at 1000
        do_reset();
        run(4, 8 * R);
        drain();
        for (int i = 4; i < 8; i++) begin
            d = vat(i) - 1000;
            check("dac_tol", (d >= -1 && d <= 1), 1);
        end

        // Reset at sample 30 of a frame
        do_reset();
        run(0, R + 30);
        check("pre_rst_dout", dout, 651);
        rst_n = 1'b0;
        #1;
        check("async_dout", dout, 0);
        check("async_valid", dout_valid, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vals.delete();
        pcyc.delete();
        step(1'b1, 1'b1);
        facc = cyc;
        run(0, R - 1);
        drain();
        check("post_rst_val", vat(0), 651);
        check("post_rst_lat", cat(0) - facc, R + LAT - 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

- Converts a 1-bit pulse-density-modulated stream back into unsigned PCM samples using a 3rd-order CIC decimator.
- It is the receive-side counterpart of `pdm_dac`: a `pdm_dac` driven with value V and looped into this block settles to an output of V (±1 LSB), given matching `DATA_BITS`.
- Used for loopback self-test of the voice/mix path and for capturing external PDM sources (e.g. a PDM microphone pin) into the synth clock domain.

## Interface

Parameters:
- `DATA_BITS`, default 12: output sample width, unsigned. Must satisfy `DATA_BITS <= 3*RATE_LOG2`.
- `RATE_LOG2`, default 6: log2 of the decimation ratio, R = 2^RATE_LOG2. The default gives R = 64.

Ports:
- `clk`, input, 1 bit: the single clock. All logic is on its rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `din`, input, 1 bit: PDM bit. 1 maps to +1, 0 maps to 0.
- `din_en`, input, 1 bit: sample strobe. `din` is accepted only on cycles where `din_en` = 1. Tie high for one bit per `clk`.
- `dout`, output, `DATA_BITS`: latest PCM sample, unsigned. Holds its value between updates.
- `dout_valid`, output, 1 bit: one-cycle pulse marking the cycle on which `dout` updates.

## Operation

- Internal width W = 3*RATE_LOG2 + 1. All integrator and comb arithmetic is modulo 2^W. Integrator wrap is legal and must not be detected or corrected.
- Integrators (pipelined, registered, update only on accepted samples, each using the previous values of the others):
  - I1 <= I1 + din
  - I2 <= I2 + I1
  - I3 <= I3 + I2
- Frame counter:
  - Counts accepted samples from 0 to R-1, then wraps to 0.
  - Accepting a sample while the counter is at R-1 raises an internal decimate flag for exactly one cycle.
- Comb stage (runs on the cycle the decimate flag is set, using the current I3):
  - C1 = I3 - D1, C2 = C1 - D2, C3 = C2 - D3, all modulo 2^W.
  - Then D1 <= I3, D2 <= C1, D3 <= C2.
- Output scaling:
  - If C3 = 2^(3*RATE_LOG2), replace it with 2^(3*RATE_LOG2) - 1 (saturation).
  - `dout` <= bits [3*RATE_LOG2-1 : 3*RATE_LOG2-DATA_BITS] of the result (truncation, no rounding). `dout_valid` <= 1.
- Transient: the first 3 outputs after reset are filter start-up transients. From the 4th output on, `dout` reflects the steady-state input density.
- `din_en` low: integrators, counter and comb state all hold. `dout` and `dout_valid` are unaffected except for a decimate flag already raised.

## Timing

- Reset values: `dout` = 0, `dout_valid` = 0. I1–I3, D1–D3, the counter and the decimate flag are all 0.
- Latency: `dout`/`dout_valid` update on the second rising edge after the edge that accepts the R-th sample of a frame. That is one edge for the integrator and flag update, one for the comb and output register.
- Throughput: with `din_en` held at 1, `dout_valid` pulses exactly once every R cycles. In general it pulses once per R accepted samples, regardless of gaps in `din_en`.
- `din_en` = 1 on the same cycle as the decimate flag: the new sample is accepted normally and counts as sample 0 of the next frame. The comb still uses I3 as registered on the prior edge.
- `rst_n` asserted mid-frame: all state clears immediately (asynchronously). The partial frame is discarded. The counter restarts at 0 on the first accepted sample after release.

## Configuration

- Macro `PDM_DECIMATOR_SYNC_EN`.
- Defined:
  - `din` and `din_en` pass through a 2-flop synchronizer (reset to 0) before use.
  - Use this for asynchronous external pins.
  - All latencies above grow by 2 cycles.
- Undefined:
  - `din` and `din_en` are used directly and must be synchronous to `clk`.

## Test plan

- Reset, then `din_en` = 1 with `din` = 1 constantly (R = 64, `DATA_BITS` = 12):
  - First `dout_valid` at 65 cycles after the first accepted sample, with `dout` = 651 (I3 = C(64,3) = 41664).
  - From the 4th pulse on, `dout` = 4095 (saturated).
  - Pulses are exactly 64 cycles apart.
- `din` = 0 constantly: every `dout` = 0, pulses every 64 cycles.
- `din` alternating 1,0,1,0…: from the 4th pulse on, `dout` = 2048 every pulse.
- `din` = 1 with `din_en` toggling 1,0,1,0…:
  - Pulses are 128 cycles apart.
  - Values are identical, pulse for pulse, to the first scenario.
- `pdm_dac` (`DATA_BITS` = 12) driven with 1000, output looped into `din`, `din_en` = 1: after the 4th pulse, `dout` stays within 1000 ±1.
- Assert `rst_n` low for 3 cycles at sample 30 of a frame:
  - `dout` and `dout_valid` read 0 immediately, asynchronously.
  - The next pulse occurs 65 cycles after the first accepted sample following release, with a value matching the first scenario's first output (651).
